pipeline_hazard_ctrl: RTL and testbench

- Stall/flush sequencer for the ID stage operand/redirect muxes.
- Consumes the ID-stage source indices, the branch/jump redirect requests, and EX/MEM producer info.
- Decides per cycle whether the PC and if_id_reg hold, whether id_ex_reg receives a bubble, and whether if_id_reg is flushed on a taken redirect.
- Also honours an external whole-pipeline hold (I/O or memory busy) and keeps saturating stall/flush performance counters.

---
 rtl/pipeline_hazard_ctrl.sv | 171 +++++++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the ID stage: load-use and branch-operand hazards,
// redirect gating, external whole-pipeline hold and saturating perf counters.
`ifndef REG_FILE_ADDR_WIDTH
`define REG_FILE_ADDR_WIDTH 5
`endif

module pipeline_hazard_ctrl #(
    parameter int unsigned CNT_WIDTH     = 16,
    parameter int unsigned REG_IDX_WIDTH = `REG_FILE_ADDR_WIDTH
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     ext_hold,
    input  logic                     id_no_op,
    input  logic [REG_IDX_WIDTH-1:0] id_reg_1_idx,
    input  logic [REG_IDX_WIDTH-1:0] id_reg_2_idx,
    input  logic                     id_branch,
    input  logic                     pc_offset,
    input  logic                     pc_overload,
    input  logic                     ex_reg_write,
    input  logic                     ex_mem_read,
    input  logic [REG_IDX_WIDTH-1:0] ex_reg_dest_idx,
    input  logic                     mem_mem_read,
    input  logic [REG_IDX_WIDTH-1:0] mem_reg_dest_idx,
    output logic                     pc_stall,
    output logic                     if_id_stall,
    output logic                     id_ex_bubble,
    output logic                     if_id_flush,
    output logic                     global_hold,
    output logic                     redirect_en,
    output logic [1:0]               ctrl_state,
    output logic [CNT_WIDTH-1:0]     stall_count,
    output logic [CNT_WIDTH-1:0]     flush_count
);

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        STALL = 2'd1,
        HOLD  = 2'd2
    } state_e;

    state_e               state_q, state_d;
    state_e               saved_state_q, saved_state_d;
    logic [1:0]           cnt_q, cnt_d;
    logic [1:0]           saved_cnt_q, saved_cnt_d;
    logic [CNT_WIDTH-1:0] stall_count_q, stall_count_d;
    logic [CNT_WIDTH-1:0] flush_count_q, flush_count_d;

    logic       match_ex;
    logic       match_mem;
    logic [1:0] need_n;
    logic       stall_now;
    logic       hold_act;

    // Hazard detection: number of stall cycles the ID instruction needs
    always_comb begin
        match_ex  = (ex_reg_dest_idx != '0) &&
                    ((ex_reg_dest_idx == id_reg_1_idx) || (ex_reg_dest_idx == id_reg_2_idx));
        match_mem = (mem_reg_dest_idx != '0) &&
                    ((mem_reg_dest_idx == id_reg_1_idx) || (mem_reg_dest_idx == id_reg_2_idx));
        need_n = 2'd0;
        if (!id_no_op) begin
            if (ex_mem_read && match_ex)
                need_n = id_branch ? 2'd2 : 2'd1;
            else if (ex_reg_write && match_ex && id_branch)
                need_n = 2'd1;
            else if (mem_mem_read && match_mem && id_branch)
                need_n = 2'd1;
        end
    end

    // Control outputs; forced low while reset is asserted
    always_comb begin
        stall_now    = ((state_q == RUN) && (need_n != 2'd0)) || (state_q == STALL);
        hold_act     = ext_hold || (state_q == HOLD);
        pc_stall     = 1'b0;
        if_id_stall  = 1'b0;
        id_ex_bubble = 1'b0;
        if_id_flush  = 1'b0;
        global_hold  = 1'b0;
        redirect_en  = 1'b0;
        if (!rst) begin
            if (hold_act) begin
                global_hold = 1'b1;
                pc_stall    = 1'b1;
                if_id_stall = 1'b1;
            end else begin
                pc_stall     = stall_now;
                if_id_stall  = stall_now;
                id_ex_bubble = stall_now;
                redirect_en  = (pc_offset | pc_overload) & ~stall_now;
                if_id_flush  = redirect_en;
            end
        end
    end

    // Next state; a hold snapshots the interrupted state and restores it on release
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        saved_state_d = saved_state_q;
        saved_cnt_d   = saved_cnt_q;
        if (ext_hold) begin
            state_d = HOLD;
            if (state_q != HOLD) begin
                saved_state_d = state_q;
                saved_cnt_d   = cnt_q;
            end
        end else begin
            case (state_q)
                RUN: begin
                    if (need_n == 2'd2) begin
                        state_d = STALL;
                        cnt_d   = 2'd1;
                    end
                end
                STALL: begin
                    if (cnt_q <= 2'd1) begin
                        cnt_d   = 2'd0;
                        state_d = RUN;
                    end else begin
                        cnt_d = cnt_q - 2'd1;
                    end
                end
                HOLD: begin
                    state_d       = saved_state_q;
                    cnt_d         = saved_cnt_q;
                    saved_state_d = RUN;
                    saved_cnt_d   = 2'd0;
                end
                default: begin
                    state_d = RUN;
                    cnt_d   = 2'd0;
                end
            endcase
        end
    end

    // Saturating performance counters
    always_comb begin
        stall_count_d = stall_count_q;
        flush_count_d = flush_count_q;
        if (stall_now && !ext_hold && (stall_count_q != '1))
            stall_count_d = stall_count_q + CNT_WIDTH'(1);
        if (if_id_flush && (flush_count_q != '1))
            flush_count_d = flush_count_q + CNT_WIDTH'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= RUN;
            saved_state_q <= RUN;
            cnt_q         <= 2'd0;
            saved_cnt_q   <= 2'd0;
            stall_count_q <= '0;
            flush_count_q <= '0;
        end else begin
            state_q       <= state_d;
            saved_state_q <= saved_state_d;
            cnt_q         <= cnt_d;
            saved_cnt_q   <= saved_cnt_d;
            stall_count_q <= stall_count_d;
            flush_count_q <= flush_count_d;
        end
    end

    assign ctrl_state  = state_q;
    assign stall_count = stall_count_q;
    assign flush_count = flush_count_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench for pipeline_hazard_ctrl: directed vectors push expectations,
// a negedge monitor pops and compares them against the DUT.
module tb_pipeline_hazard_ctrl;

    localparam int unsigned CW = 4;
    localparam int unsigned RW = 5;

    localparam logic [5:0] C_NONE  = 6'b000000;
    localparam logic [5:0] C_STALL = 6'b111000;
    localparam logic [5:0] C_HOLD  = 6'b110010;
    localparam logic [5:0] C_FLUSH = 6'b000101;

    logic          clk = 1'b0;
    logic          rst;
    logic          ext_hold, id_no_op, id_branch, pc_offset, pc_overload;
    logic          ex_reg_write, ex_mem_read, mem_mem_read;
    logic [RW-1:0] id_reg_1_idx, id_reg_2_idx, ex_reg_dest_idx, mem_reg_dest_idx;
    logic          pc_stall, if_id_stall, id_ex_bubble, if_id_flush, global_hold, redirect_en;
    logic [1:0]    ctrl_state;
    logic [CW-1:0] stall_count, flush_count;

    typedef struct {
        string      name;
        logic [1:0] st;
        logic [5:0] ctrl;
        int         sc;
        int         fc;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    pipeline_hazard_ctrl #(.CNT_WIDTH(CW), .REG_IDX_WIDTH(RW)) dut (
        .clk(clk), .rst(rst), .ext_hold(ext_hold), .id_no_op(id_no_op),
        .id_reg_1_idx(id_reg_1_idx), .id_reg_2_idx(id_reg_2_idx),
        .id_branch(id_branch), .pc_offset(pc_offset), .pc_overload(pc_overload),
        .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
        .ex_reg_dest_idx(ex_reg_dest_idx), .mem_mem_read(mem_mem_read),
        .mem_reg_dest_idx(mem_reg_dest_idx), .pc_stall(pc_stall),
        .if_id_stall(if_id_stall), .id_ex_bubble(id_ex_bubble),
        .if_id_flush(if_id_flush), .global_hold(global_hold),
        .redirect_en(redirect_en), .ctrl_state(ctrl_state),
        .stall_count(stall_count), .flush_count(flush_count)
    );

    always #5 clk = ~clk;

    task automatic clear_inputs();
        ext_hold = 0; id_no_op = 0; id_branch = 0; pc_offset = 0; pc_overload = 0;
        ex_reg_write = 0; ex_mem_read = 0; mem_mem_read = 0;
        id_reg_1_idx = '0; id_reg_2_idx = '0; ex_reg_dest_idx = '0; mem_reg_dest_idx = '0;
    endtask

    task automatic step(input string nm, input logic [1:0] st, input logic [5:0] c,
                        input int sc, input int fc);
        exp_t e;
        e.name = nm; e.st = st; e.ctrl = c; e.sc = sc; e.fc = fc;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    // Monitor: control outputs are combinational, so one expectation per cycle
    initial begin
        exp_t e;
        logic [5:0] act;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e   = exp_q.pop_front();
                act = {pc_stall, if_id_stall, id_ex_bubble, if_id_flush, global_hold, redirect_en};
                checks++;
                if (ctrl_state !== e.st) begin
                    errors++;
                    $display("FAIL %s state: got %0d expected %0d", e.name, ctrl_state, e.st);
                end
                checks++;
                if (act !== e.ctrl) begin
                    errors++;
                    $display("FAIL %s ctrl: got %b expected %b", e.name, act, e.ctrl);
                end
                checks++;
                if (int'(stall_count) != e.sc) begin
                    errors++;
                    $display("FAIL %s stall_count: got %0d expected %0d", e.name, stall_count, e.sc);
                end
                checks++;
                if (int'(flush_count) != e.fc) begin
                    errors++;
                    $display("FAIL %s flush_count: got %0d expected %0d", e.name, flush_count, e.fc);
                end
            end
        end
    end

    initial begin
        clear_inputs();
        rst = 1'b1;
        @(posedge clk);
        #1;
        // Outputs must be low under reset even with a live hazard
        ex_mem_read = 1; ex_reg_dest_idx = 5'd8; id_reg_2_idx = 5'd8;
        step("reset", 2'd0, C_NONE, 0, 0);
        rst = 1'b0;
        clear_inputs();
        step("idle", 2'd0, C_NONE, 0, 0);

        // Load-use into an ALU instruction: single stall cycle
        ex_mem_read = 1; ex_reg_dest_idx = 5'd8; id_reg_2_idx = 5'd8;
        step("lu_alu", 2'd0, C_STALL, 0, 0);
        clear_inputs();
        step("lu_alu_done", 2'd0, C_NONE, 1, 0);

        // Load feeding a taken branch: two stall cycles then the redirect
        ex_mem_read = 1; ex_reg_dest_idx = 5'd8; id_reg_2_idx = 5'd8;
        id_branch = 1; pc_offset = 1;
        step("lu_br_c1", 2'd0, C_STALL, 1, 0);
        step("lu_br_c2", 2'd1, C_STALL, 2, 0);
        ex_mem_read = 0;
        step("lu_br_flush", 2'd0, C_FLUSH, 3, 0);
        clear_inputs();
        step("lu_br_done", 2'd0, C_NONE, 3, 1);

        // Index 0 never matches; a gap never stalls
        ex_mem_read = 1;
        step("idx0", 2'd0, C_NONE, 3, 1);
        id_no_op = 1; ex_reg_dest_idx = 5'd8; id_reg_2_idx = 5'd8;
        step("no_op", 2'd0, C_NONE, 3, 1);
        clear_inputs();
        ex_reg_write = 1; ex_reg_dest_idx = 5'd5; id_reg_1_idx = 5'd5; id_branch = 1;
        step("alu_br", 2'd0, C_STALL, 3, 1);
        clear_inputs();
        mem_mem_read = 1; mem_reg_dest_idx = 5'd7; id_reg_2_idx = 5'd7; id_branch = 1;
        step("mem_ld_br", 2'd0, C_STALL, 4, 1);
        clear_inputs();
        step("mem_done", 2'd0, C_NONE, 5, 1);

        // Hold entered in the first STALL cycle; one stall cycle remains afterwards
        ex_mem_read = 1; ex_reg_dest_idx = 5'd8; id_reg_2_idx = 5'd8; id_branch = 1;
        step("hold_pre", 2'd0, C_STALL, 5, 1);
        ext_hold = 1;
        step("hold_in", 2'd1, C_HOLD, 6, 1);
        step("hold_2", 2'd2, C_HOLD, 6, 1);
        step("hold_3", 2'd2, C_HOLD, 6, 1);
        ext_hold = 0;
        step("hold_rel", 2'd2, C_HOLD, 6, 1);
        step("hold_resume", 2'd1, C_STALL, 6, 1);
        clear_inputs();
        step("hold_done", 2'd0, C_NONE, 7, 1);

        // Hold beats a hazard, which is re-evaluated after release
        ext_hold = 1; ex_mem_read = 1; ex_reg_dest_idx = 5'd8; id_reg_1_idx = 5'd8;
        step("hold_hz", 2'd0, C_HOLD, 7, 1);
        ext_hold = 0;
        step("hold_hz_rel", 2'd2, C_HOLD, 7, 1);
        step("hold_hz_eval", 2'd0, C_STALL, 7, 1);
        clear_inputs();
        step("hold_hz_done", 2'd0, C_NONE, 8, 1);

        // Reset mid-STALL and mid-HOLD
        ex_mem_read = 1; ex_reg_dest_idx = 5'd8; id_reg_2_idx = 5'd8; id_branch = 1;
        step("rst_pre", 2'd0, C_STALL, 8, 1);
        rst = 1'b1;
        step("rst_stall", 2'd0, C_NONE, 0, 0);
        rst = 1'b0;
        clear_inputs();
        step("rst_stall_after", 2'd0, C_NONE, 0, 0);
        ext_hold = 1;
        step("rst_hold_pre", 2'd0, C_HOLD, 0, 0);
        rst = 1'b1;
        step("rst_hold", 2'd0, C_NONE, 0, 0);
        rst = 1'b0;
        ext_hold = 0;
        step("rst_hold_after", 2'd0, C_NONE, 0, 0);

        // flush_count saturates at all-ones
        pc_overload = 1;
        for (int i = 1; i <= 19; i++)
            step("sat", 2'd0, C_FLUSH, 0, ((i - 1) > 15) ? 15 : (i - 1));
        clear_inputs();
        step("sat_hold", 2'd0, C_NONE, 0, 15);

        for (int k = 0; k < 10 && exp_q.size() > 0; k++)
            @(posedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
